// File: rtl/rvfi_emitter.sv
// RVFI trace producer: compacts per-port commit events and traps into registered
// rvfi_instr_t packets with a running retirement order and an M-mode ecall halt.

package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 64;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;
endpackage

package rvfi_pkg;
    localparam int unsigned ORDER_FIELD_W = 64;

    typedef struct packed {
        logic                          valid;
        logic [ORDER_FIELD_W-1:0]      order;
        logic [31:0]                   insn;
        logic                          trap;
        logic [riscv::XLEN-1:0]        cause;
        logic [1:0]                    mode;
        logic [4:0]                    rd_addr;
        logic [riscv::XLEN-1:0]        rd_wdata;
        logic [riscv::VLEN-1:0]        pc_rdata;
        logic [riscv::XLEN-1:0]        mem_addr;
        logic [riscv::XLEN/8-1:0]      mem_rmask;
        logic [riscv::XLEN/8-1:0]      mem_wmask;
        logic [riscv::XLEN-1:0]        mem_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_emitter #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned ORDER_W         = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::VLEN-1:0]   commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][31:0]              commit_insn_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]               commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN-1:0]   commit_rd_wdata_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN-1:0]   commit_mem_addr_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN/8-1:0] commit_mem_rmask_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN/8-1:0] commit_mem_wmask_i,
    input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN-1:0]   commit_mem_wdata_i,
    input  logic                                          exception_valid_i,
    input  logic [riscv::XLEN-1:0]                        exception_cause_i,
    input  logic [riscv::VLEN-1:0]                        exception_pc_i,
    input  logic [1:0]                                    priv_lvl_i,
    output logic                                          commit_ready_o,
    output rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_o,
    output logic                                          halt_o,
    output logic [ORDER_W-1:0]                            retired_cnt_o
);

    localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);
    localparam int unsigned IDX_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;
    localparam int unsigned OF_W  = rvfi_pkg::ORDER_FIELD_W;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_d;
    logic [ORDER_W-1:0]     order_q, order_d;
    logic                   pending_q, pending_d;
    logic [riscv::XLEN-1:0] pend_cause_q, pend_cause_d;
    logic [riscv::VLEN-1:0] pend_pc_q, pend_pc_d;
    logic                   halt_q, halt_d;
    logic [CNT_W-1:0]       cnt;

    assign commit_ready_o = ~rst_i & ~pending_q & ~halt_q;
    assign halt_o         = halt_q;
    assign retired_cnt_o  = order_q;

    // Next packet: either the deferred trap alone, or compacted commits plus an optional trap
    always_comb begin
        rvfi_d       = '0;
        order_d      = order_q;
        pending_d    = 1'b0;
        pend_cause_d = pend_cause_q;
        pend_pc_d    = pend_pc_q;
        halt_d       = halt_q;
        cnt          = '0;

        if (pending_q && !halt_q) begin
            rvfi_d[0].trap     = 1'b1;
            rvfi_d[0].cause    = pend_cause_q;
            rvfi_d[0].pc_rdata = pend_pc_q;
            rvfi_d[0].order    = OF_W'(order_q);
            rvfi_d[0].mode     = priv_lvl_i;
        end else if (commit_ready_o) begin
            for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (commit_valid_i[p]) begin
                    rvfi_d[cnt[IDX_W-1:0]].valid     = 1'b1;
                    rvfi_d[cnt[IDX_W-1:0]].order     = OF_W'(order_q + ORDER_W'(cnt));
                    rvfi_d[cnt[IDX_W-1:0]].insn      = commit_insn_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].mode      = priv_lvl_i;
                    rvfi_d[cnt[IDX_W-1:0]].rd_addr   = commit_rd_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].rd_wdata  = (commit_rd_i[p] == 5'd0) ? '0
                                                                               : commit_rd_wdata_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].pc_rdata  = commit_pc_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].mem_addr  = commit_mem_addr_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].mem_rmask = commit_mem_rmask_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].mem_wmask = commit_mem_wmask_i[p];
                    rvfi_d[cnt[IDX_W-1:0]].mem_wdata = commit_mem_wdata_i[p];
                    if (commit_insn_i[p] == ECALL && priv_lvl_i == riscv::PRIV_LVL_M) begin
                        halt_d = 1'b1;
                    end
                    cnt = cnt + CNT_W'(1);
                end
            end
            order_d = order_q + ORDER_W'(cnt);

            // Trap rides in the first free slot, or is deferred one cycle when all slots are full
            if (exception_valid_i) begin
                if (cnt < CNT_W'(NR_COMMIT_PORTS)) begin
                    rvfi_d[cnt[IDX_W-1:0]].trap     = 1'b1;
                    rvfi_d[cnt[IDX_W-1:0]].cause    = exception_cause_i;
                    rvfi_d[cnt[IDX_W-1:0]].pc_rdata = exception_pc_i;
                    rvfi_d[cnt[IDX_W-1:0]].order    = OF_W'(order_q + ORDER_W'(cnt));
                    rvfi_d[cnt[IDX_W-1:0]].mode     = priv_lvl_i;
                end else begin
                    pending_d    = 1'b1;
                    pend_cause_d = exception_cause_i;
                    pend_pc_d    = exception_pc_i;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvfi_o       <= '0;
            order_q      <= '0;
            pending_q    <= 1'b0;
            pend_cause_q <= '0;
            pend_pc_q    <= '0;
            halt_q       <= 1'b0;
        end else begin
            rvfi_o       <= rvfi_d;
            order_q      <= order_d;
            pending_q    <= pending_d;
            pend_cause_q <= pend_cause_d;
            pend_pc_q    <= pend_pc_d;
            halt_q       <= halt_d;
        end
    end

endmodule

// File: tb/tb_rvfi_emitter.sv
// Directed bench for rvfi_emitter: compaction, ordering, trap placement/deferral,
// ecall halt and asynchronous reset, with hand-computed expectations.

module tb_rvfi_emitter;

    localparam int unsigned N = 2;

    logic                                 clk_i = 1'b0;
    logic                                 rst_i;
    logic [N-1:0]                         commit_valid_i;
    logic [N-1:0][riscv::VLEN-1:0]        commit_pc_i;
    logic [N-1:0][31:0]                   commit_insn_i;
    logic [N-1:0][4:0]                    commit_rd_i;
    logic [N-1:0][riscv::XLEN-1:0]        commit_rd_wdata_i;
    logic [N-1:0][riscv::XLEN-1:0]        commit_mem_addr_i;
    logic [N-1:0][riscv::XLEN/8-1:0]      commit_mem_rmask_i;
    logic [N-1:0][riscv::XLEN/8-1:0]      commit_mem_wmask_i;
    logic [N-1:0][riscv::XLEN-1:0]        commit_mem_wdata_i;
    logic                                 exception_valid_i;
    logic [riscv::XLEN-1:0]               exception_cause_i;
    logic [riscv::VLEN-1:0]               exception_pc_i;
    logic [1:0]                           priv_lvl_i;
    logic                                 commit_ready_o;
    rvfi_pkg::rvfi_instr_t [N-1:0]        rvfi_o;
    logic                                 halt_o;
    logic [63:0]                          retired_cnt_o;

    int checks   = 0;
    int failures = 0;

    rvfi_emitter #(.NR_COMMIT_PORTS(N), .ORDER_W(64)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .commit_valid_i     (commit_valid_i),
        .commit_pc_i        (commit_pc_i),
        .commit_insn_i      (commit_insn_i),
        .commit_rd_i        (commit_rd_i),
        .commit_rd_wdata_i  (commit_rd_wdata_i),
        .commit_mem_addr_i  (commit_mem_addr_i),
        .commit_mem_rmask_i (commit_mem_rmask_i),
        .commit_mem_wmask_i (commit_mem_wmask_i),
        .commit_mem_wdata_i (commit_mem_wdata_i),
        .exception_valid_i  (exception_valid_i),
        .exception_cause_i  (exception_cause_i),
        .exception_pc_i     (exception_pc_i),
        .priv_lvl_i         (priv_lvl_i),
        .commit_ready_o     (commit_ready_o),
        .rvfi_o             (rvfi_o),
        .halt_o             (halt_o),
        .retired_cnt_o      (retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        commit_valid_i     = '0;
        commit_pc_i        = '0;
        commit_insn_i      = '0;
        commit_rd_i        = '0;
        commit_rd_wdata_i  = '0;
        commit_mem_addr_i  = '0;
        commit_mem_rmask_i = '0;
        commit_mem_wmask_i = '0;
        commit_mem_wdata_i = '0;
        exception_valid_i  = 1'b0;
        exception_cause_i  = '0;
        exception_pc_i     = '0;
        priv_lvl_i         = 2'b00;
    endtask

    task automatic set_port(input int p, input logic [63:0] pc, input logic [31:0] insn,
                            input logic [4:0] rd, input logic [63:0] wdata);
        commit_valid_i[p]    = 1'b1;
        commit_pc_i[p]       = pc;
        commit_insn_i[p]     = insn;
        commit_rd_i[p]       = rd;
        commit_rd_wdata_i[p] = wdata;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        #12;
        check("rst_rvfi_zero", 64'(|rvfi_o), 64'd0);
        check("rst_halt",      64'(halt_o), 64'd0);
        check("rst_retired",   retired_cnt_o, 64'd0);
        check("rst_ready",     64'(commit_ready_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", 64'(commit_ready_o), 64'd1);

        // Single commit on port 0
        set_port(0, 64'h8000_0000, 32'h0000_0013, 5'd1, 64'h55);
        priv_lvl_i = 2'b00;
        step();
        check("a_s0_valid", 64'(rvfi_o[0].valid), 64'd1);
        check("a_s0_order", rvfi_o[0].order, 64'd0);
        check("a_s0_pc",    rvfi_o[0].pc_rdata, 64'h8000_0000);
        check("a_s0_wdata", rvfi_o[0].rd_wdata, 64'h55);
        check("a_s1_valid", 64'(rvfi_o[1].valid), 64'd0);
        check("a_retired",  retired_cnt_o, 64'd1);

        // Port 1 only: compacted into slot 0; rd=0 forces wdata to 0
        clear_inputs();
        set_port(1, 64'h8000_0004, 32'h0010_0093, 5'd0, 64'h77);
        step();
        check("b_s0_valid", 64'(rvfi_o[0].valid), 64'd1);
        check("b_s0_pc",    rvfi_o[0].pc_rdata, 64'h8000_0004);
        check("b_s0_insn",  64'(rvfi_o[0].insn), 64'h0010_0093);
        check("b_s0_order", rvfi_o[0].order, 64'd1);
        check("b_s0_wdata", rvfi_o[0].rd_wdata, 64'd0);
        check("b_s1_valid", 64'(rvfi_o[1].valid), 64'd0);

        // Two full packets back to back
        clear_inputs();
        set_port(0, 64'h8000_0008, 32'h0000_0013, 5'd2, 64'h1);
        set_port(1, 64'h8000_000c, 32'h0000_0013, 5'd3, 64'h2);
        step();
        check("c1_s0_order", rvfi_o[0].order, 64'd2);
        check("c1_s1_order", rvfi_o[1].order, 64'd3);
        check("c1_s1_valid", 64'(rvfi_o[1].valid), 64'd1);
        step();
        check("c2_s0_order", rvfi_o[0].order, 64'd4);
        check("c2_s1_order", rvfi_o[1].order, 64'd5);
        check("c2_retired",  retired_cnt_o, 64'd6);

        // Idle cycle
        clear_inputs();
        step();
        check("idle_zero",    64'(|rvfi_o), 64'd0);
        check("idle_retired", retired_cnt_o, 64'd6);

        // One commit plus trap in the next slot
        set_port(0, 64'h8000_000c, 32'h0000_0013, 5'd4, 64'h3);
        exception_valid_i = 1'b1;
        exception_cause_i = 64'd2;
        exception_pc_i    = 64'h8000_0010;
        step();
        check("d_s0_valid",  64'(rvfi_o[0].valid), 64'd1);
        check("d_s0_order",  rvfi_o[0].order, 64'd6);
        check("d_s1_trap",   64'(rvfi_o[1].trap), 64'd1);
        check("d_s1_valid",  64'(rvfi_o[1].valid), 64'd0);
        check("d_s1_cause",  rvfi_o[1].cause, 64'd2);
        check("d_s1_pc",     rvfi_o[1].pc_rdata, 64'h8000_0010);
        check("d_s1_order",  rvfi_o[1].order, 64'd7);
        check("d_retired",   retired_cnt_o, 64'd7);

        // Full packet plus trap: trap deferred one cycle
        clear_inputs();
        set_port(0, 64'h8000_0100, 32'h0000_0013, 5'd5, 64'h4);
        set_port(1, 64'h8000_0104, 32'h0000_0013, 5'd6, 64'h5);
        exception_valid_i = 1'b1;
        exception_cause_i = 64'd5;
        exception_pc_i    = 64'h8000_0104;
        step();
        check("e1_s0_order", rvfi_o[0].order, 64'd7);
        check("e1_s1_order", rvfi_o[1].order, 64'd8);
        check("e1_s1_trap",  64'(rvfi_o[1].trap), 64'd0);
        check("e1_ready",    64'(commit_ready_o), 64'd0);
        check("e1_retired",  retired_cnt_o, 64'd9);
        step();
        check("e2_s0_trap",  64'(rvfi_o[0].trap), 64'd1);
        check("e2_s0_valid", 64'(rvfi_o[0].valid), 64'd0);
        check("e2_s0_cause", rvfi_o[0].cause, 64'd5);
        check("e2_s0_order", rvfi_o[0].order, 64'd9);
        check("e2_s1_empty", 64'(rvfi_o[1].valid | rvfi_o[1].trap), 64'd0);
        check("e2_ready",    64'(commit_ready_o), 64'd1);
        check("e2_retired",  retired_cnt_o, 64'd9);

        // M-mode ecall in slot 0; slot 1 still emitted
        clear_inputs();
        set_port(0, 64'h8000_0200, 32'h0000_0073, 5'd0, 64'h0);
        set_port(1, 64'h8000_0204, 32'h0000_0013, 5'd7, 64'h9);
        priv_lvl_i = 2'b11;
        step();
        check("f_halt",      64'(halt_o), 64'd1);
        check("f_ready",     64'(commit_ready_o), 64'd0);
        check("f_s0_insn",   64'(rvfi_o[0].insn), 64'h73);
        check("f_s0_mode",   64'(rvfi_o[0].mode), 64'd3);
        check("f_s1_valid",  64'(rvfi_o[1].valid), 64'd1);
        check("f_retired",   retired_cnt_o, 64'd11);
        step();
        check("f_post_zero", 64'(|rvfi_o), 64'd0);
        check("f_post_cnt",  retired_cnt_o, 64'd11);
        check("f_post_halt", 64'(halt_o), 64'd1);

        // Asynchronous reset while halted
        #2 rst_i = 1'b1;
        #1;
        check("g_halt_rst",  64'(halt_o), 64'd0);
        check("g_cnt_rst",   retired_cnt_o, 64'd0);
        check("g_ready_rst", 64'(commit_ready_o), 64'd0);
        step();
        rst_i = 1'b0;

        // Asynchronous reset mid-cycle clears a live packet
        clear_inputs();
        set_port(0, 64'h8000_0300, 32'h0000_0013, 5'd1, 64'hab);
        step();
        check("h_s0_valid",  64'(rvfi_o[0].valid), 64'd1);
        check("h_s0_order",  rvfi_o[0].order, 64'd0);
        #2 rst_i = 1'b1;
        #1;
        check("h_rvfi_rst",  64'(|rvfi_o), 64'd0);
        check("h_cnt_rst",   retired_cnt_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
